deserializer: RTL and testbench

//   Receive side of the serial link: rebuilds WIDTH-bit words from serial_in, LSB first,

---
 rtl/deserializer.sv | 141 ++++++++++++++
 tb/tb_deserializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words (LSB first) framed by a start pulse
// and delivers them through a one-word valid/ready holding register. Optional macro: DESER_FRAME_CNT_EN.
module deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             frame_err,
    input  logic             err_clr
`ifdef DESER_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    logic [0:0]       state_q,   state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-2:0] shift_q,   shift_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;
    logic             ferr_q,    ferr_d;

    logic             last_bit;
    logic             load;
    logic             drop;
    logic [WIDTH-1:0] word;

    assign last_bit = (state_q == S_RECV) && (bit_cnt_q == LAST_BIT);
    // The final bit is never stored in the shift register; it goes straight into the word.
    assign word     = {serial_in, shift_q};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ferr_d    = 1'b0;
        load      = 1'b0;
        drop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RECV;
                    bit_cnt_d = '0;
                end
            end
            S_RECV: begin
                if (last_bit) begin
                    // A start on the completing edge chains straight into the next frame.
                    if (!valid_q || data_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    bit_cnt_d = '0;
                    state_d   = start ? S_RECV : S_IDLE;
                end else if (start) begin
                    bit_cnt_d = '0;
                    ferr_d    = 1'b1;
                end else begin
                    shift_d[bit_cnt_q] = serial_in;
                    bit_cnt_d          = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            data_d  = word;
            valid_d = 1'b1;
        end
        // A new overrun on the clearing edge takes priority over the clear.
        overrun_d = (overrun_q & ~err_clr) | drop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

`ifdef DESER_FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    // Counts only words that actually entered the holding register.
    assign fcnt_d = load ? fcnt_q + 16'd1 : fcnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer (WIDTH=8); frame_cnt checks only when DESER_FRAME_CNT_EN is defined.
module tb_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic       start;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       overrun;
    logic       frame_err;
    logic       err_clr;
`ifdef DESER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int ferr_cycles = 0;

    always #5 clk = ~clk;

    deserializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .start      (start),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
`ifdef DESER_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    // Advance past one rising edge and sample; also tally frame_err high cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_err === 1'b1) ferr_cycles++;
    endtask

    // Start pulse then nbits bits of w LSB first; data_ready/err_clr take the given
    // values during the 8th bit cycle (data_ready keeps it afterwards).
    task automatic frame(input logic [7:0] w, input int nbits, input logic rdy_last, input logic clr_last);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            serial_in = w[k];
            if (k == 7) begin
                data_ready = rdy_last;
                err_clr    = clr_last;
            end
            tick();
        end
        serial_in = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
`ifdef DESER_FRAME_CNT_EN
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'hA5;
        data_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL single_early_c1: got %b want 0", data_valid); end
        for (int k = 0; k < 8; k++) begin
            serial_in = w[k];
            tick();
            if (k < 7) begin
                total++;
                if (data_valid !== 1'b0) begin bad++; $display("FAIL single_early_bit%0d: got %b want 0", k, data_valid); end
            end
        end
        serial_in = 1'b0;
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL single_valid_c9: got %b want 1", data_valid); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL single_data: got %0h want a5", data_out); end
        tick();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL single_one_cycle: got %b want 0", data_valid); end
    endtask

    task automatic test_back_to_back();
        data_ready  = 1'b1;
        ferr_cycles = 0;
        frame(8'h3C, 8, 1'b1, 1'b0);
        total++; if (data_valid !== 1'b1 || data_out !== 8'h3C) begin bad++; $display("FAIL b2b_first: got v=%b d=%0h want v=1 d=3c", data_valid, data_out); end
        tick();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b want 0", data_valid); end
        frame(8'hC3, 8, 1'b1, 1'b0);
        total++; if (data_valid !== 1'b1 || data_out !== 8'hC3) begin bad++; $display("FAIL b2b_second: got v=%b d=%0h want v=1 d=c3", data_valid, data_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        total++; if (ferr_cycles != 0) begin bad++; $display("FAIL b2b_frame_err: got %0d cycles want 0", ferr_cycles); end
`ifdef DESER_FRAME_CNT_EN
        total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL b2b_frame_cnt: got %0d want 3", frame_cnt); end
`endif
        tick();
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        frame(8'h11, 8, 1'b0, 1'b0);
        total++; if (data_valid !== 1'b1 || data_out !== 8'h11) begin bad++; $display("FAIL ovr_first: got v=%b d=%0h want v=1 d=11", data_valid, data_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_not_yet: got %b want 0", overrun); end
        tick();
        frame(8'h22, 8, 1'b0, 1'b0);
        total++; if (data_out !== 8'h11) begin bad++; $display("FAIL ovr_keep_old: got %0h want 11", data_out); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        tick();
        frame(8'h33, 8, 1'b0, 1'b1);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        total++; if (data_valid !== 1'b1 || data_out !== 8'h11) begin bad++; $display("FAIL ovr_hold: got v=%b d=%0h want v=1 d=11", data_valid, data_out); end
`ifdef DESER_FRAME_CNT_EN
        total++; if (frame_cnt !== 16'd4) begin bad++; $display("FAIL ovr_frame_cnt: got %0d want 4", frame_cnt); end
`endif
        data_ready = 1'b1;
        tick();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", data_valid); end
        data_ready = 1'b0;
    endtask

    task automatic test_same_edge();
        data_ready = 1'b0;
        frame(8'h11, 8, 1'b0, 1'b0);
        total++; if (data_valid !== 1'b1 || data_out !== 8'h11) begin bad++; $display("FAIL same_first: got v=%b d=%0h want v=1 d=11", data_valid, data_out); end
        tick();
        frame(8'h22, 8, 1'b1, 1'b0);
        total++; if (data_out !== 8'h22) begin bad++; $display("FAIL same_reload: got %0h want 22", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL same_valid: got %b want 1", data_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL same_overrun: got %b want 0", overrun); end
        tick();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL same_drain: got %b want 0", data_valid); end
    endtask

    task automatic test_abort();
        data_ready  = 1'b1;
        ferr_cycles = 0;
        frame(8'hFF, 4, 1'b1, 1'b0);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL abort_partial: got %b want 0", data_valid); end
        frame(8'h5A, 8, 1'b1, 1'b0);
        total++; if (data_valid !== 1'b1 || data_out !== 8'h5A) begin bad++; $display("FAIL abort_data: got v=%b d=%0h want v=1 d=5a", data_valid, data_out); end
        total++; if (ferr_cycles != 1) begin bad++; $display("FAIL abort_frame_err: got %0d cycles want 1", ferr_cycles); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL abort_err_low: got %b want 0", frame_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        data_ready = 1'b0;
        frame(8'h77, 8, 1'b0, 1'b0);
        total++; if (data_valid !== 1'b1 || data_out !== 8'h77) begin bad++; $display("FAIL rmid_pre: got v=%b d=%0h want v=1 d=77", data_valid, data_out); end
        tick();
        frame(8'hFF, 3, 1'b0, 1'b0);
        rst_n     = 1'b0;
        serial_in = 1'b1;
        tick();
        rst_n = 1'b1;
        total++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin bad++; $display("FAIL rmid_cleared: got v=%b d=%0h want v=0 d=0", data_valid, data_out); end
        total++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL rmid_flags: got o=%b f=%b want 0 0", overrun, frame_err); end
        for (int i = 0; i < 8; i++) tick();
        serial_in = 1'b0;
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rmid_idle_ignore: got %b want 0", data_valid); end
        data_ready = 1'b1;
        frame(8'h81, 8, 1'b1, 1'b0);
        total++; if (data_valid !== 1'b1 || data_out !== 8'h81) begin bad++; $display("FAIL rmid_next: got v=%b d=%0h want v=1 d=81", data_valid, data_out); end
`ifdef DESER_FRAME_CNT_EN
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL rmid_frame_cnt: got %0d want 1", frame_cnt); end
`endif
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        serial_in  = 1'b0;
        start      = 1'b0;
        data_ready = 1'b0;
        err_clr    = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_same_edge();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
